// File: rtl/eth_rx_frame_buffer_pkg.sv
// Shared Ethernet definitions: TX/RX state encodings, RX status codes
// and the tkeep population-count helper.
package eth_rx_frame_buffer_pkg;

  // Transmit framer states, kept here so both directions share one package.
  typedef enum logic [1:0] {
    e_tx_idle = 2'd0,
    e_tx_send = 2'd1,
    e_tx_done = 2'd2
  } eth_tx_state_e;

  typedef enum logic [1:0] {
    e_rx    = 2'd0,
    e_drop  = 2'd1,
    e_avail = 2'd2
  } eth_rx_state_e;

  // Codes reported through the MMIO RX status register.
  localparam logic [1:0] rx_ext_idle_c  = 2'b00;
  localparam logic [1:0] rx_ext_busy_c  = 2'b01;
  localparam logic [1:0] rx_ext_avail_c = 2'b10;
  localparam logic [1:0] rx_ext_drop_c  = 2'b11;

  function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, keep[i]};
    return n;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read word memory with a synchronous write port and an
// asynchronous (combinational) read port.
module bsg_mem_1r1w #(
  parameter int width_p = 64,
  parameter int els_p   = 192,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  // NOTE: storage arrays are deliberately not reset; a word is only ever
  // read after it has been written, so a reset would just cost logic.
  always_ff @(posedge w_clk_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = r_v_i ? mem[r_addr_i] : '0;

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Buffers one received Ethernet frame and hands it to MMIO as length + words.
// Optional drop statistics counter enabled by `define ETH_RX_DROP_STATS_EN.
module eth_rx_frame_buffer
  import eth_rx_frame_buffer_pkg::*;
#(
  parameter int max_words_p       = 192,
  parameter int axis_data_width_p = 64,
  localparam int len_width_lp     = $clog2(max_words_p*8+1)
) (
  input  logic                           bp_clk_i,
  input  logic                           bp_reset_i,

  input  logic [axis_data_width_p-1:0]   rx_axis_tdata_i,
  input  logic [axis_data_width_p/8-1:0] rx_axis_tkeep_i,
  input  logic                           rx_axis_tvalid_i,
  output logic                           rx_axis_tready_o,
  input  logic                           rx_axis_tlast_i,
  input  logic                           rx_axis_tuser_i,

  output logic                           frame_v_o,
  output logic [len_width_lp-1:0]        frame_len_o,
  output logic [axis_data_width_p-1:0]   frame_data_o,
  output logic                           frame_data_v_o,
  input  logic                           frame_data_yumi_i,
  input  logic                           frame_release_i,

  output logic [1:0]                     rx_ext_state_o,
  output logic [15:0]                    drop_count_o
);

  localparam int addr_width_lp = $clog2(max_words_p);
  localparam int ptr_width_lp  = $clog2(max_words_p+1);

  eth_rx_state_e           state_r, state_n;
  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [len_width_lp-1:0] frame_len_r;
  logic [3:0]              keep_cnt;
  logic beat_acc, rx_beat, frame_empty, last_good, last_drop, overflow;
  logic drop_event, release_ok, pop;

  assign rx_axis_tready_o = (state_r != e_avail);
  assign beat_acc         = rx_axis_tvalid_i & rx_axis_tready_o;
  assign rx_beat          = beat_acc & (state_r == e_rx);
  assign keep_cnt         = keep_popcount(rx_axis_tkeep_i);
  assign frame_empty      = (wr_ptr_r == '0) && (keep_cnt == '0);
  assign last_drop        = rx_beat & rx_axis_tlast_i & (rx_axis_tuser_i | frame_empty);
  assign last_good        = rx_beat & rx_axis_tlast_i & ~(rx_axis_tuser_i | frame_empty);
  // A tlast beat at the final slot is legal; only a non-last beat there overflows.
  assign overflow         = rx_beat & ~rx_axis_tlast_i
                          & (wr_ptr_r == ptr_width_lp'(max_words_p-1));
  assign drop_event       = last_drop | overflow;
  assign release_ok       = (state_r == e_avail) & frame_release_i;
  assign pop              = frame_data_v_o & frame_data_yumi_i;

  assign frame_v_o        = (state_r == e_avail);
  assign frame_data_v_o   = (state_r == e_avail) && (rd_ptr_r < wr_ptr_r);
  assign frame_len_o      = frame_len_r;

  always_ff @(posedge bp_clk_i) begin
    if (bp_reset_i) state_r <= e_rx;
    else            state_r <= state_n;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_n (no latch).
    state_n = state_r;
    case (state_r)
      e_rx: begin
        if (last_good)     state_n = e_avail;
        else if (overflow) state_n = e_drop;
      end
      e_drop:  if (beat_acc && rx_axis_tlast_i) state_n = e_rx;
      e_avail: if (frame_release_i)             state_n = e_rx;
      default: state_n = e_rx;
    endcase
  end

  always_comb begin
    rx_ext_state_o = rx_ext_idle_c;
    case (state_r)
      e_rx:    rx_ext_state_o = (wr_ptr_r == '0) ? rx_ext_idle_c : rx_ext_busy_c;
      e_drop:  rx_ext_state_o = rx_ext_drop_c;
      e_avail: rx_ext_state_o = rx_ext_avail_c;
      default: rx_ext_state_o = rx_ext_idle_c;
    endcase
  end

  // wr_ptr doubles as the stored word count once the frame is available.
  always_ff @(posedge bp_clk_i) begin
    if (bp_reset_i) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      frame_len_r <= '0;
    end else begin
      if (drop_event || release_ok) wr_ptr_r <= '0;
      else if (rx_beat)             wr_ptr_r <= wr_ptr_r + 1'b1;

      if (release_ok) rd_ptr_r <= '0;
      else if (pop)   rd_ptr_r <= rd_ptr_r + 1'b1;

      if (last_good)
        frame_len_r <= len_width_lp'({wr_ptr_r, 3'b000}) + len_width_lp'(keep_cnt);
    end
  end

  bsg_mem_1r1w #(
    .width_p (axis_data_width_p),
    .els_p   (max_words_p)
  ) u_mem (
    .w_clk_i  (bp_clk_i),
    .w_v_i    (rx_beat),
    .w_addr_i (wr_ptr_r[addr_width_lp-1:0]),
    .w_data_i (rx_axis_tdata_i),
    .r_v_i    (frame_data_v_o),
    .r_addr_i (rd_ptr_r[addr_width_lp-1:0]),
    .r_data_o (frame_data_o)
  );

`ifdef ETH_RX_DROP_STATS_EN
  logic [15:0] drop_count_r;

  always_ff @(posedge bp_clk_i) begin
    if (bp_reset_i)                                drop_count_r <= '0;
    else if (drop_event && drop_count_r != 16'hFFFF) drop_count_r <= drop_count_r + 16'd1;
  end

  assign drop_count_o = drop_count_r;
`else
  assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Scoreboard bench for eth_rx_frame_buffer: driver pushes expected lengths and
// words, an independent monitor compares whatever the DUT presents.
module tb_eth_rx_frame_buffer;

  localparam int MAX_WORDS = 192;

  logic        bp_clk_i = 1'b0;
  logic        bp_reset_i;
  logic [63:0] rx_axis_tdata_i;
  logic [7:0]  rx_axis_tkeep_i;
  logic        rx_axis_tvalid_i;
  logic        rx_axis_tready_o;
  logic        rx_axis_tlast_i;
  logic        rx_axis_tuser_i;
  logic        frame_v_o;
  logic [10:0] frame_len_o;
  logic [63:0] frame_data_o;
  logic        frame_data_v_o;
  logic        frame_data_yumi_i;
  logic        frame_release_i;
  logic [1:0]  rx_ext_state_o;
  logic [15:0] drop_count_o;

  eth_rx_frame_buffer #(.max_words_p(MAX_WORDS), .axis_data_width_p(64)) dut (
    .bp_clk_i          (bp_clk_i),
    .bp_reset_i        (bp_reset_i),
    .rx_axis_tdata_i   (rx_axis_tdata_i),
    .rx_axis_tkeep_i   (rx_axis_tkeep_i),
    .rx_axis_tvalid_i  (rx_axis_tvalid_i),
    .rx_axis_tready_o  (rx_axis_tready_o),
    .rx_axis_tlast_i   (rx_axis_tlast_i),
    .rx_axis_tuser_i   (rx_axis_tuser_i),
    .frame_v_o         (frame_v_o),
    .frame_len_o       (frame_len_o),
    .frame_data_o      (frame_data_o),
    .frame_data_v_o    (frame_data_v_o),
    .frame_data_yumi_i (frame_data_yumi_i),
    .frame_release_i   (frame_release_i),
    .rx_ext_state_o    (rx_ext_state_o),
    .drop_count_o      (drop_count_o)
  );

  always #5 bp_clk_i = ~bp_clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: expected per-frame lengths/word counts and words.
  int          exp_len_q[$];
  int          exp_nw_q[$];
  logic [63:0] exp_word_q[$];
  int          exp_drops = 0;

  logic auto_consume = 1'b1;
  logic man_yumi     = 1'b0;
  logic man_release  = 1'b0;
  logic early_rel    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic logic [15:0] exp_drop_count();
`ifdef ETH_RX_DROP_STATS_EN
    return (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
`else
    return 16'h0000;
`endif
  endfunction

  // Frame is good unless flagged bad, empty, or longer than the buffer.
  task automatic send_frame(input int nbeats, input int nkeep, input logic bad,
                            input int chk_beat);
    logic [7:0]  keep;
    logic [63:0] w;
    logic        good, accepted;
    int          waited;
    keep = 8'((9'd1 << nkeep) - 9'd1);
    good = !(bad || nbeats > MAX_WORDS || (nbeats == 1 && nkeep == 0));
    if (good) begin
      exp_len_q.push_back(8*(nbeats-1) + nkeep);
      exp_nw_q.push_back(nbeats);
    end else begin
      exp_drops++;
    end
    for (int i = 0; i < nbeats; i++) begin
      w = {$urandom, $urandom};
      if (good) exp_word_q.push_back(w);
      if ($urandom_range(0, 3) == 0) begin
        rx_axis_tvalid_i = 1'b0;
        @(posedge bp_clk_i); #1;
      end
      rx_axis_tvalid_i = 1'b1;
      rx_axis_tdata_i  = w;
      rx_axis_tlast_i  = (i == nbeats-1);
      rx_axis_tkeep_i  = rx_axis_tlast_i ? keep : 8'($urandom);
      rx_axis_tuser_i  = rx_axis_tlast_i ? bad : 1'($urandom);
      accepted = 1'b0;
      waited   = 0;
      while (!accepted) begin
        @(negedge bp_clk_i) accepted = rx_axis_tready_o;
        @(posedge bp_clk_i); #1;
        if (!accepted && ++waited > 2000) begin
          fail("beat_accept_timeout");
          rx_axis_tvalid_i = 1'b0;
          return;
        end
      end
      if (i == chk_beat) check("ext_state_after_overflow", 64'(rx_ext_state_o), 64'(2'b11));
    end
    rx_axis_tvalid_i = 1'b0;
    rx_axis_tlast_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_len_q.size() != 0 || frame_v_o) && n < 5000) begin
      @(posedge bp_clk_i); #1;
      n++;
    end
    if (n >= 5000) fail("idle_timeout");
  endtask

  task automatic manual_pop_all();
    int guard = 0;
    while (frame_data_v_o && guard < 400) begin
      man_yumi = 1'b1;
      @(posedge bp_clk_i); #1;
      guard++;
    end
    man_yumi    = 1'b0;
    man_release = 1'b1;
    @(posedge bp_clk_i); #1;
    man_release = 1'b0;
  endtask

  // Consumer: random pops and releases, or replays the manual controls.
  initial begin
    frame_data_yumi_i = 1'b0;
    frame_release_i   = 1'b0;
    forever begin
      @(posedge bp_clk_i); #2;
      if (auto_consume) begin
        frame_data_yumi_i = frame_data_v_o && ($urandom_range(0, 3) != 0);
        frame_release_i   = frame_v_o && !frame_data_v_o && ($urandom_range(0, 1) == 1);
      end else begin
        frame_data_yumi_i = man_yumi;
        frame_release_i   = man_release;
      end
    end
  end

  // Monitor: compares each presented frame and popped word with the model.
  initial begin
    logic prev_fv;
    int   words_left;
    int   exp_len;
    prev_fv    = 1'b0;
    words_left = 0;
    forever begin
      @(negedge bp_clk_i);
      if (frame_v_o && !prev_fv) begin
        if (exp_len_q.size() == 0) begin
          fail("unexpected_frame");
          words_left = 0;
        end else begin
          exp_len    = exp_len_q.pop_front();
          words_left = exp_nw_q.pop_front();
          check("frame_len", 64'(frame_len_o), 64'(exp_len));
        end
      end
      if (frame_v_o && frame_release_i) begin
        if (!early_rel) check("words_left_at_release", 64'(words_left), 64'd0);
        while (words_left > 0 && exp_word_q.size() > 0) begin
          void'(exp_word_q.pop_front());
          words_left--;
        end
        words_left = 0;
      end else if (frame_data_v_o && frame_data_yumi_i) begin
        if (words_left == 0 || exp_word_q.size() == 0) begin
          fail("unexpected_word");
        end else begin
          check("frame_word", frame_data_o, exp_word_q.pop_front());
          words_left--;
        end
      end
      prev_fv = frame_v_o;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nk;
    int hi_cycles;
    logic bad;
    rx_axis_tdata_i  = '0;
    rx_axis_tkeep_i  = '0;
    rx_axis_tvalid_i = 1'b0;
    rx_axis_tlast_i  = 1'b0;
    rx_axis_tuser_i  = 1'b0;
    bp_reset_i       = 1'b1;
    repeat (3) @(posedge bp_clk_i);
    #1 bp_reset_i = 1'b0;

    check("reset_tready",     64'(rx_axis_tready_o), 64'd1);
    check("reset_frame_v",    64'(frame_v_o),        64'd0);
    check("reset_data_v",     64'(frame_data_v_o),   64'd0);
    check("reset_frame_len",  64'(frame_len_o),      64'd0);
    check("reset_ext_state",  64'(rx_ext_state_o),   64'd0);
    check("reset_drop_count", 64'(drop_count_o),     64'd0);

    // 60-byte frame: 8 beats, last keep 0x0F.
    send_frame(8, 4, 1'b0, -1);
    check("frame_v_after_tlast", 64'(frame_v_o),        64'd1);
    check("tready_after_tlast",  64'(rx_axis_tready_o), 64'd0);
    check("ext_state_avail",     64'(rx_ext_state_o),   64'(2'b10));
    wait_idle();
    check("ext_state_after_release", 64'(rx_ext_state_o), 64'd0);

    // Bad frame, then a good 64-byte frame.
    send_frame(5, 8, 1'b1, -1);
    check("frame_v_after_bad",   64'(frame_v_o),    64'd0);
    check("drop_count_bad",      64'(drop_count_o), 64'(exp_drop_count()));
    send_frame(8, 8, 1'b0, -1);
    wait_idle();

    // 200-beat overflow.
    send_frame(200, 8, 1'b0, MAX_WORDS-1);
    check("ext_state_after_overflow_tlast", 64'(rx_ext_state_o), 64'd0);
    check("drop_count_overflow", 64'(drop_count_o), 64'(exp_drop_count()));

    // Second frame offered while the first is held.
    auto_consume = 1'b0;
    send_frame(6, 8, 1'b0, -1);
    fork
      send_frame(10, 2, 1'b0, -1);
      begin
        hi_cycles = 0;
        repeat (20) begin
          @(negedge bp_clk_i);
          if (rx_axis_tready_o) hi_cycles++;
        end
        check("tready_high_while_avail", 64'(hi_cycles), 64'd0);
        @(posedge bp_clk_i); #1;
        manual_pop_all();
      end
    join
    auto_consume = 1'b1;
    wait_idle();

    // Yumi and release together on the second word.
    auto_consume = 1'b0;
    send_frame(5, 8, 1'b0, -1);
    man_yumi = 1'b1;
    @(posedge bp_clk_i); #1;
    early_rel   = 1'b1;
    man_release = 1'b1;
    man_yumi    = 1'b1;
    @(posedge bp_clk_i); #1;
    man_yumi    = 1'b0;
    man_release = 1'b0;
    early_rel   = 1'b0;
    check("ext_state_after_yumi_release", 64'(rx_ext_state_o),   64'd0);
    check("frame_v_after_yumi_release",   64'(frame_v_o),        64'd0);
    check("data_v_after_yumi_release",    64'(frame_data_v_o),   64'd0);
    check("tready_after_yumi_release",    64'(rx_axis_tready_o), 64'd1);
    auto_consume = 1'b1;
    send_frame(3, 5, 1'b0, -1);
    wait_idle();

    // Empty single beat.
    send_frame(1, 0, 1'b0, -1);
    check("frame_v_after_empty", 64'(frame_v_o),    64'd0);
    check("drop_count_empty",    64'(drop_count_o), 64'(exp_drop_count()));

    // Randomized frames including the exact-fit and overflow boundaries.
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 9))
        0:       nb = MAX_WORDS;
        1:       nb = MAX_WORDS + 1 + int'($urandom_range(0, 3));
        default: nb = int'($urandom_range(1, 16));
      endcase
      nk  = int'($urandom_range(1, 8));
      bad = ($urandom_range(0, 9) == 0);
      send_frame(nb, nk, bad, -1);
    end
    wait_idle();
    check("drop_count_final", 64'(drop_count_o), 64'(exp_drop_count()));
    check("ext_state_final",  64'(rx_ext_state_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
